// File: rtl/mac_result_collector.sv
// rtl/mac_result_collector.sv - MAC result stream FIFO with valid/ready read port and overflow tracking
// Optional drop counter enabled by MAC_COLLECTOR_DROPCNT_EN; otherwise drop_count is tied to zero.
module mac_result_collector #(
  parameter int DATA_WIDTH = 40,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      in_val,
  input  logic                       in_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [15:0]                drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [LVL_W-1:0] LVL_ONE   = 1;
  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_full = (r_level == LVL_DEPTH);
  assign w_pop  = out_valid && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign level     = r_level;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Setting wins over clearing so a drop coincident with clear_ovf is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef MAC_COLLECTOR_DROPCNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      if (clear_ovf) begin
        r_drop_count <= 16'd1;
      end else if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end else if (clear_ovf) begin
      r_drop_count <= 16'd0;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
// tb/tb_mac_result_collector.sv - directed vector bench for mac_result_collector (DEPTH=4, DATA_WIDTH=40)
module tb_mac_result_collector;

`ifdef MAC_COLLECTOR_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] in_val;
  logic        in_valid;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        iv;
    logic [39:0] val;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [39:0] ed;
    logic [2:0]  el;
    logic        eo;
    logic [15:0] edc;
  } vec_t;

  vec_t tbl[$];

  mac_result_collector #(.DATA_WIDTH(40), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val     (in_val),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic iv, input logic [39:0] val, input logic rdy, input logic clr,
                     input logic ev, input logic [39:0] ed, input logic [2:0] el,
                     input logic eo, input logic [15:0] edc);
    vec_t v;
    v.iv = iv; v.val = val; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.edc = DROP_EN ? edc : 16'd0;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [39:0] ed,
                         input logic [2:0] el, input logic eo, input logic [15:0] edc);
    n_vec++;
    chk({nm, " out_valid"},  64'(out_valid),  64'(ev));
    chk({nm, " out_data"},   64'(out_data),   64'(ed));
    chk({nm, " level"},      64'(level),      64'(el));
    chk({nm, " overflow"},   64'(overflow),   64'(eo));
    chk({nm, " drop_count"}, 64'(drop_count), 64'(edc));
  endtask

  initial begin
    rst_n = 1'b0; in_val = '0; in_valid = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;

    //   iv  val          rdy clr   ev  data         lvl ovf drop
    // pass-through
    add(1, 40'h11, 1, 0,   1, 40'h11, 3'd1, 0, 16'd0);
    add(1, 40'h22, 1, 0,   1, 40'h22, 3'd1, 0, 16'd0);
    add(1, 40'h33, 1, 0,   1, 40'h33, 3'd1, 0, 16'd0);
    add(0, 40'h0,  1, 0,   0, 40'h0,  3'd0, 0, 16'd0);
    add(0, 40'h0,  1, 0,   0, 40'h0,  3'd0, 0, 16'd0);
    // backpressure fill
    add(1, 40'h41, 0, 0,   1, 40'h41, 3'd1, 0, 16'd0);
    add(1, 40'h42, 0, 0,   1, 40'h41, 3'd2, 0, 16'd0);
    add(1, 40'h43, 0, 0,   1, 40'h41, 3'd3, 0, 16'd0);
    add(1, 40'h44, 0, 0,   1, 40'h41, 3'd4, 0, 16'd0);
    // overflow drop of 0xAA
    add(1, 40'hAA, 0, 0,   1, 40'h41, 3'd4, 1, 16'd1);
    // full push+pop of 0xBB, then drain
    add(1, 40'hBB, 1, 0,   1, 40'h42, 3'd4, 1, 16'd1);
    add(0, 40'h0,  1, 0,   1, 40'h43, 3'd3, 1, 16'd1);
    add(0, 40'h0,  1, 0,   1, 40'h44, 3'd2, 1, 16'd1);
    add(0, 40'h0,  1, 0,   1, 40'hBB, 3'd1, 1, 16'd1);
    add(0, 40'h0,  1, 0,   0, 40'h0,  3'd0, 1, 16'd1);
    add(0, 40'h0,  0, 1,   0, 40'h0,  3'd0, 0, 16'd0);
    // clear race
    add(1, 40'h51, 0, 0,   1, 40'h51, 3'd1, 0, 16'd0);
    add(1, 40'h52, 0, 0,   1, 40'h51, 3'd2, 0, 16'd0);
    add(1, 40'h53, 0, 0,   1, 40'h51, 3'd3, 0, 16'd0);
    add(1, 40'h54, 0, 0,   1, 40'h51, 3'd4, 0, 16'd0);
    add(1, 40'hCC, 0, 1,   1, 40'h51, 3'd4, 1, 16'd1);
    add(0, 40'h0,  0, 1,   1, 40'h51, 3'd4, 0, 16'd0);
    add(1, 40'hDD, 0, 0,   1, 40'h51, 3'd4, 1, 16'd1);
    add(1, 40'hEE, 0, 0,   1, 40'h51, 3'd4, 1, 16'd2);
    add(0, 40'h0,  1, 0,   1, 40'h52, 3'd3, 1, 16'd2);
    add(0, 40'h0,  1, 0,   1, 40'h53, 3'd2, 1, 16'd2);
    add(0, 40'h0,  1, 0,   1, 40'h54, 3'd1, 1, 16'd2);
    add(0, 40'h0,  1, 0,   0, 40'h0,  3'd0, 1, 16'd2);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_all("reset", 1'b0, 40'h0, 3'd0, 1'b0, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].iv;
      in_val    = tbl[i].val;
      out_ready = tbl[i].rdy;
      clear_ovf = tbl[i].clr;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo, tbl[i].edc);
    end

    // no bypass: a beat presented to an empty FIFO is invisible until the edge
    in_valid = 1'b1; in_val = 40'h77; out_ready = 1'b0; clear_ovf = 1'b0;
    #2;
    chk_all("nobypass", 1'b0, 40'h0, 3'd0, 1'b1, DROP_EN ? 16'd2 : 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("latency", 1'b1, 40'h77, 3'd1, 1'b1, DROP_EN ? 16'd2 : 16'd0);
    in_val = 40'h78;
    @(posedge clk);
    @(negedge clk);
    in_val = 40'h79;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_all("prereset", 1'b1, 40'h77, 3'd3, 1'b1, DROP_EN ? 16'd2 : 16'd0);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_all("asyncreset", 1'b0, 40'h0, 3'd0, 1'b0, 16'd0);
    @(negedge clk);
    in_valid = 1'b1; in_val = 40'h5A;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_all("afterreset", 1'b1, 40'h5A, 3'd1, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
